// File: rtl/rv_decode_queue.sv
// RV32I decoder feeding a DEPTH-entry FIFO of {ROM index, illegal flag, PC}.
// Optional feature macro: RV_DECODE_CSR_EN (decode csrrw/csrrwi on the SYSTEM opcode).
module rv_decode_queue #(
  parameter int DEPTH = 2,
  parameter int IDX_W = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_illegal,
  output logic [31:0]      out_pc,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             illegal;
    logic [31:0]      pc;
  } entry_t;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [5:0] code;
  logic       legal;
  entry_t     new_entry, head;
  logic       unused_instr_bits;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];
  assign unused_instr_bits = ^{in_instr[24:15], in_instr[11:7]};

  always_comb begin
    code  = '0;
    legal = 1'b0;
    case (opc)
      7'h33: begin
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        case (f3)
          3'd0: code = f7[5] ? 6'd1 : 6'd0;
          3'd1: code = 6'd2;
          3'd2: code = 6'd3;
          3'd3: code = 6'd4;
          3'd4: code = 6'd5;
          3'd5: code = f7[5] ? 6'd7 : 6'd6;
          3'd6: code = 6'd8;
          3'd7: code = 6'd9;
        endcase
      end
      7'h03: begin
        legal = 1'b1;
        case (f3)
          3'd0: code = 6'd10;
          3'd1: code = 6'd11;
          3'd2: code = 6'd12;
          3'd4: code = 6'd13;
          3'd5: code = 6'd14;
          default: legal = 1'b0;
        endcase
      end
      7'h13: begin
        legal = 1'b1;
        case (f3)
          3'd0: code = 6'd15;
          3'd1: begin code = 6'd16; legal = (f7 == 7'h00); end
          3'd2: code = 6'd17;
          3'd3: code = 6'd18;
          3'd4: code = 6'd19;
          3'd5: begin
            code  = f7[5] ? 6'd21 : 6'd20;
            legal = (f7 == 7'h00) || (f7 == 7'h20);
          end
          3'd6: code = 6'd22;
          3'd7: code = 6'd23;
        endcase
      end
      7'h37: begin code = 6'd24; legal = 1'b1; end
      7'h17: begin code = 6'd25; legal = 1'b1; end
      7'h6F: begin code = 6'd26; legal = 1'b1; end
      7'h67: begin code = 6'd27; legal = (f3 == 3'd0); end
      7'h63: begin
        legal = 1'b1;
        case (f3)
          3'd0: code = 6'd28;
          3'd1: code = 6'd29;
          3'd4: code = 6'd30;
          3'd5: code = 6'd31;
          3'd6: code = 6'd32;
          3'd7: code = 6'd33;
          default: legal = 1'b0;
        endcase
      end
      7'h23: begin
        legal = 1'b1;
        case (f3)
          3'd0: code = 6'd34;
          3'd1: code = 6'd35;
          3'd2: code = 6'd36;
          default: legal = 1'b0;
        endcase
      end
`ifdef RV_DECODE_CSR_EN
      7'h73: begin
        legal = 1'b1;
        case (f3)
          3'd1: code = 6'd37;
          3'd5: code = 6'd38;
          default: legal = 1'b0;
        endcase
      end
`endif
      default: legal = 1'b0;
    endcase
  end

  assign new_entry.idx     = legal ? IDX_W'(code) : '1;
  assign new_entry.illegal = ~legal;
  assign new_entry.pc      = in_pc;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic             push, pop;

  // No pass-through when full: in_ready looks only at occupancy and flush.
  assign in_ready  = (count_q < FULL) & ~flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready & ~flush;

  assign head        = mem_q[rptr_q];
  assign out_idx     = head.idx;
  assign out_illegal = head.illegal;
  assign out_pc      = head.pc;
  assign illegal_cnt = icnt_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    icnt_d  = icnt_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + OCC_W'(1);
      else if (pop && !push) count_d = count_q - OCC_W'(1);
    end
    if (push && new_entry.illegal && icnt_q != '1) icnt_d = icnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      icnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      icnt_q  <= icnt_d;
      if (push) mem_q[wptr_q] <= new_entry;
    end
  end
endmodule

// File: tb/tb_rv_decode_queue.sv
// Directed + random bench for rv_decode_queue against a table-driven decode/queue model.
module tb_rv_decode_queue;
  localparam int DEPTH = 2, IDX_W = 6, CNT_W = 8;

  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = 0, in_pc = 0;
  logic in_ready, out_valid, out_illegal;
  logic [IDX_W-1:0] out_idx;
  logic [31:0] out_pc;
  logic [CNT_W-1:0] illegal_cnt;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  rv_decode_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_illegal(out_illegal), .out_pc(out_pc), .illegal_cnt(illegal_cnt));

  // {opcode, funct3 (-1 = any), funct7 (-1 = any), ROM index}
  int tbl [0:36][0:3] = '{
    '{51,0,0,0}, '{51,0,32,1}, '{51,1,0,2}, '{51,2,0,3}, '{51,3,0,4}, '{51,4,0,5},
    '{51,5,0,6}, '{51,5,32,7}, '{51,6,0,8}, '{51,7,0,9},
    '{3,0,-1,10}, '{3,1,-1,11}, '{3,2,-1,12}, '{3,4,-1,13}, '{3,5,-1,14},
    '{19,0,-1,15}, '{19,1,0,16}, '{19,2,-1,17}, '{19,3,-1,18}, '{19,4,-1,19},
    '{19,5,0,20}, '{19,5,32,21}, '{19,6,-1,22}, '{19,7,-1,23},
    '{55,-1,-1,24}, '{23,-1,-1,25}, '{111,-1,-1,26}, '{103,0,-1,27},
    '{99,0,-1,28}, '{99,1,-1,29}, '{99,4,-1,30}, '{99,5,-1,31}, '{99,6,-1,32}, '{99,7,-1,33},
    '{35,0,-1,34}, '{35,1,-1,35}, '{35,2,-1,36}};

  typedef struct { int idx; bit ill; logic [31:0] pc; } ent_t;
  ent_t mq[$];
  int   mcnt = 0;

  function automatic int ref_decode(input logic [31:0] w);
    int opc, f3, f7;
    opc = int'(w[6:0]);
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    for (int i = 0; i < 37; i++)
      if (tbl[i][0] == opc && (tbl[i][1] < 0 || tbl[i][1] == f3) &&
          (tbl[i][2] < 0 || tbl[i][2] == f7)) return tbl[i][3];
`ifdef RV_DECODE_CSR_EN
    if (opc == 115 && f3 == 1) return 37;
    if (opc == 115 && f3 == 5) return 38;
`endif
    return 63;
  endfunction

  function automatic logic [31:0] mk_legal(input int r);
    logic [31:0] w;
    w = $urandom;
    w[6:0] = 7'(tbl[r][0]);
    if (tbl[r][1] >= 0) w[14:12] = 3'(tbl[r][1]);
    if (tbl[r][2] >= 0) w[31:25] = 7'(tbl[r][2]);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from a negedge, check pre-edge outputs, then advance the model.
  task automatic step(input bit v, input logic [31:0] w, input logic [31:0] pc,
                      input bit rdy, input bit fl);
    bit ep, eo;
    int d;
    in_valid = v; in_instr = w; in_pc = pc; out_ready = rdy; flush = fl;
    #1;
    chk("out_valid", out_valid, mq.size() != 0);
    chk("in_ready", in_ready, (mq.size() < DEPTH) && !fl);
    chk("illegal_cnt", illegal_cnt, mcnt);
    if (mq.size() != 0) begin
      chk("out_idx", out_idx, mq[0].idx);
      chk("out_illegal", out_illegal, mq[0].ill);
      chk("out_pc", out_pc, mq[0].pc);
    end
    ep = v && (mq.size() < DEPTH) && !fl;
    eo = (mq.size() != 0) && rdy;
    d  = ref_decode(w);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (eo) void'(mq.pop_front());
      if (ep) begin
        mq.push_back('{d, d == 63, pc});
        if (d == 63 && mcnt < 255) mcnt++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] w1, w2, w3;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cnt", illegal_cnt, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_illegal", out_illegal, 0);
    @(negedge clk); rst_n = 1;

    // back-to-back decode, one cycle latency
    step(1, 32'h00208033, 32'h100, 1, 0); chk("lat_add", out_idx, 0); chk("lat_vld", out_valid, 1);
    step(1, 32'h40208033, 32'h104, 1, 0); chk("lat_sub", out_idx, 1);
    step(1, 32'h4020D093, 32'h108, 1, 0); chk("lat_srai", out_idx, 21);
    step(0, 0, 0, 1, 0);

    // backpressure, full refusal, ordering
    w1 = mk_legal(2); w2 = mk_legal(12); w3 = mk_legal(30);
    step(1, w1, 32'h200, 0, 0);
    step(1, w2, 32'h204, 0, 0);
    chk("full_ready", in_ready, 0);
    step(1, w3, 32'h208, 0, 0);
    step(1, w3, 32'h208, 1, 0); chk("order2", out_pc, 32'h204);
    step(1, w3, 32'h208, 1, 0); chk("order3", out_pc, 32'h208);
    step(0, 0, 0, 1, 0);

    // flush on a full queue with an illegal word offered
    step(1, 32'h0000007F, 32'h300, 0, 0);
    step(1, mk_legal(0), 32'h304, 0, 0);
    step(1, 32'hFFFFFFFF, 32'h308, 0, 1);
    flush = 0; in_valid = 0; #1;
    chk("flush_vld", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_cnt", illegal_cnt, 1);

    // illegal words and counter saturation
    step(1, 32'h0000007F, 32'h400, 1, 0); chk("ill_flag", out_illegal, 1); chk("ill_idx", out_idx, 63);
    step(1, 32'h02208033, 32'h404, 1, 0); chk("ill_m_idx", out_idx, 63);
    for (int i = 0; i < 300; i++) step(1, $urandom | 32'h7F, 32'h500 + 4*i, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("cnt_sat", illegal_cnt, 255);

    // SYSTEM csrrw
    step(1, 32'h34029073, 32'h600, 0, 0);
`ifdef RV_DECODE_CSR_EN
    chk("csrrw", out_idx, 37);
`else
    chk("csrrw", out_idx, 63);
`endif
    step(0, 0, 0, 1, 0);

    // asynchronous reset with two entries queued
    step(1, mk_legal(5), 32'h700, 0, 0);
    step(1, mk_legal(20), 32'h704, 0, 0);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_vld", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_cnt", illegal_cnt, 0);
    mq.delete(); mcnt = 0;
    @(negedge clk); rst_n = 1;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      w = ($urandom_range(0, 3) == 0) ? $urandom : mk_legal($urandom_range(0, 36));
      step($urandom_range(0, 3) != 0, w, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
